// File: rtl/iter_rshift_pkg.sv
// Shared types and defaults for the iterative right shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iter_rshift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/iter_rshift_if.sv
// Request/response bundle between the shifter and its requester.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the result side.
interface iter_rshift_if
    import iter_rshift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_arith;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               busy;

    // Requester side: offers operands, consumes results.
    modport master (
        output in_valid, in_data, in_shamt, in_arith, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Shifter side.
    modport slave (
        input  in_valid, in_data, in_shamt, in_arith, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/iter_rshift_step.sv
// One combinational shift step: right by 1 or 2 with a supplied fill bit.
// Latency: combinational.
// Backpressure: none.
module rshift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             fill,
    input  logic             two_bit,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH+1:0] ext;

    // Prepend two fill bits, shift, keep the low WIDTH bits.
    always_comb begin
        ext    = {fill, fill, value};
        result = WIDTH'(ext >> (two_bit ? 2'd2 : 2'd1));
    end

endmodule

// File: rtl/iter_rshift.sv
// Iterative logical/arithmetic right shifter, up to 2 bit positions per cycle.
// Latency: accept edge N -> out_valid in cycle N+1+ceil(shamt/2).
// Backpressure: result held in DONE until out_ready; no new request until back in IDLE.
module iter_rshift
    import iter_rshift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_rshift_if.slave  bus
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               fill_q, fill_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               two_bit;
    logic [WIDTH-1:0]   step_out;

    assign two_bit = (rem_q >= SHAMT_W'(2));

    rshift_step #(.WIDTH(WIDTH)) u_step (
        .value   (work_q),
        .fill    (fill_q),
        .two_bit (two_bit),
        .result  (step_out)
    );

    // Next-state logic. The fill bit is captured once at accept so the
    // working register's MSB can change freely during the shift.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    work_d  = bus.in_data;
                    rem_d   = bus.in_shamt;
                    fill_d  = bus.in_arith & bus.in_data[WIDTH-1];
                    state_d = (bus.in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = step_out;
                rem_d  = two_bit ? (rem_q - SHAMT_W'(2)) : (rem_q - SHAMT_W'(1));
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered copies decoded from the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and registered outputs. in_ready resets low so the
    // unit only advertises readiness once reset has been released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            fill_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            fill_q      <= fill_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_iter_rshift.sv
// Self-checking bench for iter_rshift: directed corner cases plus random
// operations compared against a plain-arithmetic shift model.
module tb_iter_rshift;
    import iter_rshift_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iter_rshift_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    iter_rshift #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the shift itself, straight from the arithmetic definition.
    function automatic logic [31:0] model(input logic [31:0] d, input int s, input bit a);
        logic signed [31:0] sd;
        sd = d;
        if (a) return 32'(sd >>> s);
        return d >> s;
    endfunction

    task automatic scramble();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = $urandom;
        bus.in_shamt = 5'($urandom);
        bus.in_arith = 1'($urandom_range(0, 1));
    endtask

    // Issue one request (called just after a negedge), check latency,
    // result, hold stability under backpressure, and return to IDLE.
    task automatic run_op(input string tag, input logic [31:0] d, input int s,
                          input bit a, input int hold);
        int          k;
        logic [31:0] exp;
        exp = model(d, s, a);
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = 5'(s);
        bus.in_arith = a;
        @(posedge clk);
        #1 scramble();
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) break;
            scramble();
        end
        check({tag, " latency"}, 32'(k), 32'(1 + (s + 1) / 2));
        check({tag, " data"}, bus.out_data, exp);
        check({tag, " in_ready done"}, 32'(bus.in_ready), 32'd0);
        check({tag, " busy done"}, 32'(bus.busy), 32'd1);
        repeat (hold) begin
            scramble();
            @(negedge clk);
            check({tag, " hold data"}, bus.out_data, exp);
            check({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, " back idle in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, " back idle out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " back idle busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cnt;
        logic [31:0] d;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_arith  = 1'b0;
        bus.out_ready = 1'b0;

        // Outputs while reset is held.
        #12;
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", bus.out_data, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post reset in_ready", 32'(bus.in_ready), 32'd1);

        // Directed corners.
        run_op("srl 8000_0000 >> 4",  32'h8000_0000, 4,  1'b0, 0);
        check("srl4 model", model(32'h8000_0000, 4, 1'b0), 32'h0800_0000);
        run_op("sra 8000_0000 >> 31", 32'h8000_0000, 31, 1'b1, 0);
        run_op("srl 8000_0000 >> 31", 32'h8000_0000, 31, 1'b0, 0);
        run_op("srl f000_0000 >> 3",  32'hF000_0000, 3,  1'b0, 0);
        run_op("sra f000_0000 >> 3",  32'hF000_0000, 3,  1'b1, 0);
        run_op("shamt 0",             32'h1234_5678, 0,  1'b1, 0);
        run_op("backpressure",        32'hDEAD_BEEF, 7,  1'b1, 5);
        run_op("sra positive",        32'h7FFF_FFFF, 30, 1'b1, 1);
        run_op("srl one",             32'hFFFF_FFFF, 1,  1'b0, 0);

        // Random operations.
        for (int i = 0; i < 25; i++) begin
            run_op("random", $urandom, int'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a long shift.
        d = $urandom;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = 5'd20;
        bus.in_arith = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset out_data", bus.out_data, 32'd0);
        check("midreset in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) cnt++;
        end
        check("midreset no stale valid", 32'(cnt), 32'd0);
        check("midreset in_ready after", 32'(bus.in_ready), 32'd1);
        run_op("after midreset", 32'hA5A5_0F0F, 9, 1'b1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iter_rshift.md
ITER_RSHIFT -- requirements
Module: iter_rshift

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift amount width in bits (log2 WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  request offered.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_shamt  input  SHAMT_W  right-shift amount, 0..WIDTH-1.
REQ-009 SHALL have port in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_data  output  WIDTH  shifted result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM with states IDLE, SHIFT, DONE.
REQ-015 In IDLE: in_ready=1, out_valid=0; in_valid=1 completes accept on that edge.
REQ-016 On accept: latch in_data into working register, remaining=in_shamt, fill bit = in_arith ? in_data[WIDTH-1] : 0.
REQ-017 On accept: next state DONE if in_shamt==0, else SHIFT.
REQ-018 In SHIFT, each cycle: if remaining>=2 shift right by 2 with two fill bits, remaining-=2; else shift right by 1 with one fill bit, remaining-=1.
REQ-019 SHIFT -> DONE on the edge where remaining reaches 0.
REQ-020 Latency: request accepted on edge N gives out_valid=1 in cycle N+1+ceil(shamt/2) (shamt=0: N+1; shamt=31: N+17).
REQ-021 In DONE: out_valid=1, out_data = working register, held stable until out_ready=1.
REQ-022 DONE -> IDLE on edge with out_valid&&out_ready; no new request accepted in that same cycle (in_ready=0 outside IDLE).
REQ-023 in_valid, in_data, in_shamt, in_arith SHALL be ignored outside IDLE; latched operand unaffected.
REQ-024 out_data SHALL equal logical (in_arith=0) or arithmetic (in_arith=1) right shift of in_data by in_shamt, bit-exact.
REQ-025 Fill bit SHALL be fixed at accept time, not re-derived from the working register.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, working register 0, remaining 0, fill 0.
REQ-027 During reset: in_ready=0? No -- in_ready=1 only after rst_n deasserts; out_valid=0, out_data=0, busy=0 while rst_n=0.
REQ-028 Reset mid-operation (SHIFT or DONE) SHALL discard the request; no out_valid pulse follows release.

Structure
REQ-029 Shared package SHALL hold state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH/SHAMT_W constants.
REQ-030 Combinational per-cycle stage SHALL be sub-module rshift_step (inputs: value, fill, two_bit select; output: shifted value).
REQ-031 FSM, counter and working register SHALL live in iter_rshift; no other storage.

Verification
REQ-032 SRL 0x80000000 shamt 4, accept edge N -> out_data 0x08000000, out_valid first high cycle N+3.
REQ-033 SRA 0x80000000 shamt 31 -> out_data 0xFFFFFFFF at N+17; SRL same operand -> 0x00000001.
REQ-034 Odd amount: SRL 0xF0000000 shamt 3 -> 0x1E000000 at N+3; SRA 0xF0000000 shamt 3 -> 0xFE000000.
REQ-035 shamt 0, 0x12345678 -> out_valid at N+1, out_data 0x12345678; in_ready low that cycle.
REQ-036 Backpressure: hold out_ready=0 five cycles in DONE, toggle in_valid/in_data -> out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-037 Reset mid-SHIFT (shamt 20, rst_n low cycle N+3) -> busy=0, out_valid=0 immediately; after release in_ready=1, no stale output.
